// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: multiplier FSM states, default datapath
// width and the Booth recoding pairs examined on each iteration.
`timescale 1ns/1ps
package dsp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mult_state_t;

   localparam int DSP_WIDTH = 8;

   // {current LSB, previously shifted-out bit}
   localparam logic [1:0] BOOTH_SUB = 2'b10;
   localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative signed radix-2 Booth multiplier, one result per n+1 cycles.
// Optional Qn-1 fractional output port enabled by defining DSP_MULT_FRAC_EN.
`timescale 1ns/1ps
module seq_multiplier
   import dsp_pkg::*;
#(
   parameter int n = DSP_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [n-1:0]      a,
   input  logic [n-1:0]      b,
   output logic              busy,
   output logic              done,
   output logic [2*n-1:0]    product
`ifdef DSP_MULT_FRAC_EN
   ,
   output logic [n-1:0]      frac_result
`endif
);

   localparam int CW = $clog2(n + 1);

   mult_state_t             state, state_nxt;
   logic signed [n-1:0]     mcand;
   logic signed [2*n:0]     acc, acc_step;
   logic [CW-1:0]           cnt;
   logic signed [n:0]       upper_ext, addend, sum;
   logic                    accept;

`ifdef DSP_MULT_FRAC_EN
   localparam logic signed [2*n-1:0] FRAC_MAX = {{(n+1){1'b0}}, {(n-1){1'b1}}};

   // Only (-1.0)*(-1.0) lands above the Qn-1 range after the shift.
   function automatic logic signed [n-1:0] sat_frac(input logic signed [2*n-1:0] p);
      logic signed [2*n-1:0] s;
      s = p >>> (n - 1);
      if (s > FRAC_MAX)
         return FRAC_MAX[n-1:0];
      return s[n-1:0];
   endfunction
`endif

   // Booth step: the upper half is widened to n+1 bits so subtracting the most
   // negative multiplicand cannot overflow; the extra bit survives the shift.
   always_comb begin
      upper_ext = {acc[2*n], acc[2*n:n+1]};
      addend    = {mcand[n-1], mcand};
      case (acc[1:0])
         BOOTH_SUB: sum = upper_ext - addend;
         BOOTH_ADD: sum = upper_ext + addend;
         default:   sum = upper_ext;
      endcase
      acc_step = {sum, acc[n:1]};
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == '0)
               state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mcand       <= '0;
         acc         <= '0;
         cnt         <= '0;
         product     <= '0;
`ifdef DSP_MULT_FRAC_EN
         frac_result <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            mcand <= a;
            acc   <= {{n{1'b0}}, b, 1'b0};
            cnt   <= CW'(n - 1);
         end else if (state == RUN) begin
            acc <= acc_step;
            if (cnt != '0) begin
               cnt <= cnt - CW'(1);
            end else begin
               product     <= acc_step[2*n:1];
`ifdef DSP_MULT_FRAC_EN
               frac_result <= sat_frac(acc_step[2*n:1]);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboarded bench for seq_multiplier: directed timing/boundary cases plus
// randomized operands against an integer-multiply reference model.
`timescale 1ns/1ps
module tb_seq_multiplier;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   a, b;
   logic           busy, done;
   logic [2*N-1:0] product;
`ifdef DSP_MULT_FRAC_EN
   logic [N-1:0]   frac_result;
`endif

   typedef struct packed {
      logic [2*N-1:0] p;
      logic [N-1:0]   f;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   seq_multiplier #(.n(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
`ifdef DSP_MULT_FRAC_EN
      ,
      .frac_result (frac_result)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sx(input logic [N-1:0] v);
      return int'($signed(v));
   endfunction

   // Reference: exact integer product, then floor-shift and clamp for Qn-1.
   function automatic exp_t model(input int x, input int y);
      exp_t   e;
      longint p, f;
      p = longint'(x) * longint'(y);
      f = p >>> (N - 1);
      if (f > longint'((2 ** (N - 1)) - 1))
         f = longint'((2 ** (N - 1)) - 1);
      e.p = p[2*N-1:0];
      e.f = f[N-1:0];
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expectation on every done pulse.
   always @(negedge clk) begin
      if (!rst && done) begin
         chk("busy_low_at_done", busy, 1'b0);
         if (sbq.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("product", product, e.p);
`ifdef DSP_MULT_FRAC_EN
            chk("frac_result", frac_result, e.f);
`endif
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while ((busy || done) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("idle_timeout", 1'b1, 1'b0);
   endtask

   // Returns at the negedge of the first RUN cycle; cyc then equals the accept edge.
   task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, output int acc_c);
      wait_idle();
      a     = x;
      b     = y;
      start = 1'b1;
      sbq.push_back(model(sx(x), sx(y)));
      @(negedge clk);
      start = 1'b0;
      acc_c = cyc;
   endtask

   task automatic wait_done(output int done_c, output int busy_cnt);
      int k = 0;
      busy_cnt = 0;
      while (!done && k < 50) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk("done_timeout", 1'b1, 1'b0);
      done_c = cyc;
   endtask

   initial begin
      int   c0, c1, d1, d2, bc;
      exp_t held;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_product", product, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      // 7 * -3: n busy cycles, done n edges after acceptance
      issue(8'd7, 8'hFD, c0);
      wait_done(c1, bc);
      chk("lat_7x-3", c1 - c0, N);
      chk("busy_cycles_7x-3", bc, N);
      chk("p_7x-3", product, 16'hFFEB);

      issue(8'h80, 8'h80, c0);
      wait_done(c1, bc);
      chk("p_min_x_min", product, 16'h4000);
`ifdef DSP_MULT_FRAC_EN
      chk("frac_sat", frac_result, 8'h7F);
`endif
      issue(8'h40, 8'h40, c0);
      wait_done(c1, bc);
      chk("p_40x40", product, 16'h1000);
`ifdef DSP_MULT_FRAC_EN
      chk("frac_40x40", frac_result, 8'h20);
`endif

      // Back-to-back with start held high; operands change during RUN
      wait_idle();
      a     = 8'd5;
      b     = 8'd5;
      start = 1'b1;
      sbq.push_back(model(5, 5));
      sbq.push_back(model(127, -1));
      @(negedge clk);
      a = 8'd127;
      b = 8'hFF;
      wait_done(d1, bc);
      chk("p_b2b_first", product, 16'h0019);
      @(negedge clk);
      chk("b2b_reaccept_busy", busy, 1'b1);
      wait_done(d2, bc);
      start = 1'b0;
      chk("b2b_spacing", d2 - d1, N + 1);
      chk("p_b2b_second", product, 16'hFF81);
      @(negedge clk);
      chk("b2b_idle_after", busy, 1'b0);

      // Asynchronous reset 4 cycles into 100 * 100
      issue(8'd100, 8'd100, c0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      sbq.delete();
      #1;
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_product", product, 16'h0000);
`ifdef DSP_MULT_FRAC_EN
      chk("async_rst_frac", frac_result, 8'h00);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(8'd2, 8'd3, c0);
      wait_done(c1, bc);
      chk("lat_after_rst", c1 - c0, N);
      chk("p_2x3", product, 16'h0006);

      // Operands changed right after acceptance; product held through next RUN
      wait_idle();
      a     = 8'd9;
      b     = 8'hF5;
      start = 1'b1;
      sbq.push_back(model(9, -11));
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      wait_done(c1, bc);
      held = model(9, -11);
      issue(8'd3, 8'd4, c0);
      for (int i = 0; i < N - 1; i++) begin
         chk("product_held", product, held.p);
         @(negedge clk);
      end
      wait_done(c1, bc);

      // Randomized operands, with extremes mixed in
      for (int i = 0; i < 1000; i++) begin
         logic [N-1:0] x, y;
         x = 8'($urandom);
         y = 8'($urandom);
         if ($urandom_range(0, 15) == 0) x = 8'h80;
         if ($urandom_range(0, 15) == 0) y = 8'h80;
         if ($urandom_range(0, 15) == 0) y = 8'h7F;
         issue(x, y, c0);
         wait_done(c1, bc);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Iterative signed radix-2 Booth multiplier for the DSP datapath.
- Sits directly upstream of the n-bit DSP adder and produces the partial products that the adder accumulates in MAC sequences.
- Trades latency (n+1 cycles) for area; one multiplication in flight at a time.
- Start/done handshake so the control unit can sequence multiply-then-add operations.

Parameters:
- n, 8, operand width in bits (signed two's complement); must match the downstream adder's n; legal n >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a multiply; sampled on rising clk.
- a  input  n  signed multiplicand; captured when start is accepted.
- b  input  n  signed multiplier; captured when start is accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: product valid.
- product  output  2n  signed full-precision product; held until the next accepted start.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high. rst asserted at any time, including mid-operation, forces: state=IDLE, busy=0, done=0, product=0, internal accumulator/counter=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k -> capture a, b, go to RUN. Load accumulator {n'b0, b, 1'b0} (2n+1 bits) and counter=n-1.
  - RUN: each cycle performs one Booth step on the accumulator LSB pair. 10 -> upper n+1 bits minus sign-extended a. 01 -> plus a. 00/11 -> no change. Then arithmetic shift right by 1. Counter decrements; when counter==0 and the step completes, go to DONE.
  - DONE: done=1 for exactly one cycle. product = accumulator[2n:1], registered. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept, new operands captured).
- Timing: start sampled at edge k -> busy=1 from k+1 through k+n -> done=1 and product valid in cycle k+n+1. Throughput is one result per n+1 cycles.
- busy=1 only in RUN; done=1 only in DONE; busy and done are never both high.
- start while in RUN is ignored; no queuing, no error flag.
- a and b may change freely after acceptance; captured values are used.
- Arithmetic: upper-half add/sub is n+1 bits wide so that a = -2^(n-1) cannot overflow. product is exact for all operand pairs, including (-2^(n-1))*(-2^(n-1)) = +2^(2n-2).
- product is updated only on the DONE transition; it is stable otherwise.

Optional Feature:
- Macro: DSP_MULT_FRAC_EN.
- Defined:
  - Adds output port frac_result, output, n bits: Qn-1 fractional product = product >>> (n-1), truncated toward -inf.
  - Saturates to +(2^(n-1)-1) when the shifted value exceeds the n-bit range; only possible for (-1.0)*(-1.0).
  - Registered alongside product, same timing, reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Shared package dsp_pkg:
  - mult_state_t enum {IDLE, RUN, DONE}.
  - localparam DSP_WIDTH=8, used as the default n by both the adder and the multiplier.
  - Booth code constants.
- No sub-module: the Booth step add/sub is inline combinational logic in the same module. The existing adder is not reused here because it lacks carry-in/subtract.

Test Plan:
- 7 * -3, start single pulse -> busy high 8 cycles; done pulse exactly 9 cycles after start edge; product=16'hFFEB; busy low in the done cycle.
- -128 * -128 -> product=16'h4000. With DSP_MULT_FRAC_EN, frac_result=8'h7F (saturated). 8'h40 * 8'h40 -> frac_result=8'h20, product=16'h1000.
- Back-to-back: hold start=1 continuously with 5*5 then 127*-1 -> done pulses 9 cycles apart; products 16'h0019 then 16'hFF81; start during RUN does not restart.
- Reset mid-operation: assert rst asynchronously 4 cycles into 100*100 -> busy, done, product go 0 immediately, without waiting for an edge. After release, 2*3 -> 16'h0006 with normal latency.
- Operand hold: change a, b on the cycle after acceptance -> result reflects captured operands. Product held unchanged during a subsequent RUN until the next done.
- Random: 1000 random signed operand pairs, compared against an a*b golden model -> zero mismatches; done never coincides with busy.
